// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and FSM states for the register file arbiter
package regfile_pkg;
  localparam int DW_DEF = 8;
  localparam int AW_DEF = 3;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
endpackage

// File: rtl/regfile_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin picker, grants the pointer side on contention
module rr_arb2 (
  input  logic req_a,
  input  logic req_b,
  input  logic ptr,
  output logic gnt_b,
  output logic nptr
);
  assign gnt_b = req_b & (~req_a | ptr);
  assign nptr = ~gnt_b;
endmodule

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: round-robin arbitration of two requesters onto one register file port
module regfile_arbiter
  import regfile_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_wr,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_wr,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] rf_addr,
  output logic          rf_rd,
  output logic          rf_wr,
  output logic [DW-1:0] rf_wdata,
  input  logic [DW-1:0] rf_rdata,
  output logic          busy
);
  state_t state, nxt;
  logic ptr, sel, lwr, gnt_b, nptr, go, rd, w_wr;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  rr_arb2 u_arb (.req_a(a_req), .req_b(b_req), .ptr(ptr), .gnt_b(gnt_b), .nptr(nptr));
  always_comb begin
    go = state == IDLE && (a_req || b_req);
    rd = state == ACCESS && !lwr;
    w_wr = gnt_b ? b_wr : a_wr;
    w_addr = gnt_b ? b_addr : a_addr;
    w_wdata = gnt_b ? b_wdata : a_wdata;
    nxt = go ? ACCESS : rd ? RESP : IDLE;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
      sel <= 1'b0;
      lwr <= 1'b0;
      a_gnt <= 1'b0;
      b_gnt <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
      rf_addr <= '0;
      rf_rd <= 1'b0;
      rf_wr <= 1'b0;
      rf_wdata <= '0;
      busy <= 1'b0;
    end else begin
      if (go) begin
        ptr <= nptr;
        sel <= gnt_b;
        lwr <= w_wr;
      end
      a_gnt <= go & ~gnt_b;
      b_gnt <= go & gnt_b;
      rf_rd <= go & ~w_wr;
      rf_wr <= go & w_wr;
      rf_addr <= go ? w_addr : '0;
      rf_wdata <= go ? w_wdata : '0;
      a_rvalid <= rd & ~sel;
      b_rvalid <= rd & sel;
      if (rd && !sel) a_rdata <= rf_rdata;
      if (rd && sel) b_rdata <= rf_rdata;
      busy <= nxt != IDLE;
    end
  end
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed and random checks of regfile_arbiter against a transaction model
module tb_regfile_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic a_req = 1'b0, a_wr = 1'b0, b_req = 1'b0, b_wr = 1'b0;
  logic [2:0] a_addr = '0, b_addr = '0, rf_addr;
  logic [7:0] a_wdata = '0, b_wdata = '0, a_rdata, b_rdata, rf_wdata, rf_rdata;
  logic a_gnt, a_rvalid, b_gnt, b_rvalid, rf_rd, rf_wr, busy;
  always #5 clk = ~clk;
  regfile_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .rf_addr(rf_addr), .rf_rd(rf_rd), .rf_wr(rf_wr), .rf_wdata(rf_wdata),
    .rf_rdata(rf_rdata), .busy(busy)
  );
  logic [7:0] rf_mem [8] = '{default: 8'h00};
  assign rf_rdata = rf_mem[rf_addr];
  always @(negedge clk) if (rf_wr) rf_mem[rf_addr] <= rf_wdata;
  typedef struct packed {
    logic wr;
    logic [2:0] addr;
    logic [7:0] wdata;
  } op_t;
  typedef struct packed {
    logic ga, gb, va, vb, rd, wr, busy;
    logic [2:0] addr;
    logic [7:0] wdata, rdata;
  } exp_t;
  op_t qa[$], qb[$];
  exp_t cur, n1;
  int cnt, vectors = 0, miscompares = 0, g, arv, brv;
  logic ptr_m;
  logic [7:0] ea, eb;
  logic [7:0] mm [8] = '{default: 8'h00};
  function automatic op_t mk(input logic wr, input logic [2:0] ad, input logic [7:0] d);
    op_t o;
    o.wr = wr;
    o.addr = ad;
    o.wdata = d;
    return o;
  endfunction
  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic drive();
    a_req = qa.size() > 0;
    b_req = qb.size() > 0;
    if (a_req) {a_wr, a_addr, a_wdata} = qa[0];
    if (b_req) {b_wr, b_addr, b_wdata} = qb[0];
  endtask
  // predicts the outputs for the cycle after the coming rising edge
  task automatic model();
    logic wb, idle;
    op_t o;
    if (rst) begin
      cur = '0;
      n1 = '0;
      cnt = 0;
      ptr_m = 1'b0;
      ea = '0;
      eb = '0;
    end else begin
      cur = n1;
      n1 = '0;
      idle = cnt == 0;
      if (!idle) cnt--;
      if (idle && (a_req || b_req)) begin
        wb = (a_req && b_req) ? ptr_m : b_req;
        ptr_m = !wb;
        o = wb ? qb[0] : qa[0];
        cur.ga = !wb;
        cur.gb = wb;
        cur.rd = !o.wr;
        cur.wr = o.wr;
        cur.addr = o.addr;
        cur.wdata = o.wdata;
        if (o.wr) begin
          mm[o.addr] = o.wdata;
          cnt = 1;
        end else begin
          n1.va = !wb;
          n1.vb = wb;
          n1.rdata = mm[o.addr];
          cnt = 2;
        end
      end
      cur.busy = cnt > 0;
      if (cur.va) ea = cur.rdata;
      if (cur.vb) eb = cur.rdata;
    end
  endtask
  task automatic check();
    cmp("a_gnt", 32'(a_gnt), 32'(cur.ga));
    cmp("b_gnt", 32'(b_gnt), 32'(cur.gb));
    cmp("a_rvalid", 32'(a_rvalid), 32'(cur.va));
    cmp("b_rvalid", 32'(b_rvalid), 32'(cur.vb));
    cmp("a_rdata", 32'(a_rdata), 32'(ea));
    cmp("b_rdata", 32'(b_rdata), 32'(eb));
    cmp("rf_rd", 32'(rf_rd), 32'(cur.rd));
    cmp("rf_wr", 32'(rf_wr), 32'(cur.wr));
    cmp("busy", 32'(busy), 32'(cur.busy));
    if (cur.rd || cur.wr) cmp("rf_addr", 32'(rf_addr), 32'(cur.addr));
    if (cur.wr) cmp("rf_wdata", 32'(rf_wdata), 32'(cur.wdata));
    cmp("rd_wr_both", 32'(rf_rd & rf_wr), 0);
    cmp("gnt_both", 32'(a_gnt & b_gnt), 0);
    cmp("rvalid_both", 32'(a_rvalid & b_rvalid), 0);
  endtask
  task automatic tick();
    drive();
    model();
    @(negedge clk);
    check();
    if (a_gnt === 1'b1 && qa.size() > 0) void'(qa.pop_front());
    if (b_gnt === 1'b1 && qb.size() > 0) void'(qb.pop_front());
  endtask
  initial begin
    repeat (2) tick();
    cmp("rst_busy", 32'(busy), 0);
    cmp("rst_a_rdata", 32'(a_rdata), 0);
    cmp("rst_rf_wr", 32'(rf_wr), 0);
    rst = 1'b0;
    qa.push_back(mk(1'b1, 3'd1, 8'h02));
    tick();
    cmp("w1_a_gnt", 32'(a_gnt), 1);
    cmp("w1_rf_wr", 32'(rf_wr), 1);
    cmp("w1_rf_addr", 32'(rf_addr), 1);
    cmp("w1_rf_wdata", 32'(rf_wdata), 2);
    tick();
    cmp("w1_busy_done", 32'(busy), 0);
    qa.push_back(mk(1'b0, 3'd1, 8'h00));
    tick();
    cmp("r1_rf_rd", 32'(rf_rd), 1);
    tick();
    cmp("r1_a_rvalid", 32'(a_rvalid), 1);
    cmp("r1_a_rdata", 32'(a_rdata), 2);
    tick();
    rst = 1'b1;
    qa.delete();
    qb.delete();
    tick();
    rst = 1'b0;
    repeat (2) begin
      qa.push_back(mk(1'b1, 3'd2, 8'h01));
      qb.push_back(mk(1'b1, 3'd3, 8'h03));
    end
    g = 0;
    repeat (10) begin
      tick();
      if (a_gnt || b_gnt) g = g * 4 + (a_gnt ? 1 : 0) + (b_gnt ? 2 : 0);
    end
    cmp("rr_order_abab", 32'(g), 32'h66);
    qb.push_back(mk(1'b1, 3'd7, 8'h05));
    repeat (3) tick();
    qa.push_back(mk(1'b1, 3'd0, 8'h00));
    qb.push_back(mk(1'b0, 3'd7, 8'h00));
    g = 0;
    arv = 0;
    brv = 0;
    repeat (6) begin
      tick();
      if (a_gnt || b_gnt) g = g * 4 + (a_gnt ? 1 : 0) + (b_gnt ? 2 : 0);
      arv += a_rvalid ? 1 : 0;
      brv += b_rvalid ? 1 : 0;
    end
    cmp("mix_order_ab", 32'(g), 6);
    cmp("mix_a_rvalid_count", 32'(arv), 0);
    cmp("mix_b_rvalid_count", 32'(brv), 1);
    cmp("mix_b_rdata", 32'(b_rdata), 5);
    qb.push_back(mk(1'b0, 3'd3, 8'h00));
    tick();
    cmp("abort_b_gnt", 32'(b_gnt), 1);
    rst = 1'b1;
    qa.delete();
    qb.delete();
    tick();
    cmp("abort_b_rvalid", 32'(b_rvalid), 0);
    cmp("abort_b_rdata", 32'(b_rdata), 0);
    cmp("abort_busy", 32'(busy), 0);
    rst = 1'b0;
    qa.push_back(mk(1'b1, 3'd4, 8'h44));
    qb.push_back(mk(1'b1, 3'd5, 8'h55));
    tick();
    cmp("post_rst_a_gnt", 32'(a_gnt), 1);
    cmp("post_rst_b_gnt", 32'(b_gnt), 0);
    repeat (4) tick();
    for (int i = 0; i < 1000; i++) begin
      if (qa.size() == 0 && $urandom_range(1) == 1)
        qa.push_back(mk(1'($urandom_range(1)), 3'($urandom_range(7)), 8'($urandom)));
      if (qb.size() == 0 && $urandom_range(1) == 1)
        qb.push_back(mk(1'($urandom_range(1)), 3'($urandom_range(7)), 8'($urandom)));
      tick();
    end
    repeat (5) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
